// File: rtl/mod_pipe_pkg.sv
// Shared definitions for the modulation pipeline: sequencer states and segment constants.
package mod_pipe_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  localparam int unsigned SEG_W = 32;

  // Compared against by the datapath's zero check; the sequencer only forwards it.
  localparam logic [SEG_W-1:0] ZERO_CODE = 32'd0;

endpackage

// File: rtl/mod_valid_delay.sv
// Fixed-depth delay line for the {issue, final} tags so they line up with the
// datapath's registered segment result.
module mod_valid_delay #(
  parameter int unsigned Depth = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic issue_i,
  input  logic final_i,
  output logic issue_o,
  output logic final_o,
  output logic any_o
);

  logic [Depth-1:0] issue_q;
  logic [Depth-1:0] final_q;

  // Shift both tags one stage per cycle; reset empties the whole line.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_q <= '0;
      final_q <= '0;
    end else begin
      issue_q[0] <= issue_i;
      final_q[0] <= final_i;
      for (int i = 1; i < Depth; i++) begin
        issue_q[i] <= issue_q[i-1];
        final_q[i] <= final_q[i-1];
      end
    end
  end

  // Oldest stage drives the outputs; any set issue bit means samples are in flight.
  always_comb begin
    issue_o = issue_q[Depth-1];
    final_o = final_q[Depth-1];
    any_o   = |issue_q;
  end

endmodule

// File: rtl/mod_segment_sequencer.sv
// Serialises handshaked data words LSB-first, SPB samples per bit, drives the
// datapath's bit/index inputs and re-tags its registered result as a sample stream.
module mod_segment_sequencer
  import mod_pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned SPB      = 4,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned PIPE_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic [SEG_W-1:0]  bit_out,
  output logic [SEG_W-1:0]  zero_out,
  output logic [IDX_W-1:0]  sample_idx,
  input  logic [SEG_W-1:0]  seg_in,
  output logic [SEG_W-1:0]  out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e             state_q;
  logic [DATA_W-1:0]  word_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [IDX_W-1:0]   samp_cnt_q;

  logic               issue;
  logic               samp_wrap;
  logic               final_cyc;
  logic               cur_bit;
  logic [DATA_W-1:0]  word_shift;
  logic               dly_issue;
  logic               dly_final;
  logic               dly_any;

  // Decode the current sample position from the counters.
  always_comb begin
    issue      = (state_q == RUN);
    samp_wrap  = (samp_cnt_q == IDX_W'(SPB - 1));
    final_cyc  = issue && samp_wrap && (bit_cnt_q == BIT_W'(DATA_W - 1));
    // Shift rather than index so a 1-bit word never sees an oversized select.
    word_shift = word_q >> bit_cnt_q;
    cur_bit    = word_shift[0];
  end

  // FSM plus bit/sample counters; a word arriving on the final sample reloads gap-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      word_q     <= '0;
      bit_cnt_q  <= '0;
      samp_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (word_valid) begin
            word_q     <= word_data;
            bit_cnt_q  <= '0;
            samp_cnt_q <= '0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (final_cyc) begin
            bit_cnt_q  <= '0;
            samp_cnt_q <= '0;
            if (word_valid) begin
              word_q <= word_data;
            end else begin
              state_q <= IDLE;
            end
          end else if (samp_wrap) begin
            samp_cnt_q <= '0;
            bit_cnt_q  <= bit_cnt_q + BIT_W'(1);
          end else begin
            samp_cnt_q <= samp_cnt_q + IDX_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mod_valid_delay #(
    .Depth (PIPE_LAT)
  ) u_valid_delay (
    .clk     (clk),
    .reset   (reset),
    .issue_i (issue),
    .final_i (final_cyc),
    .issue_o (dly_issue),
    .final_o (dly_final),
    .any_o   (dly_any)
  );

  // Datapath drive and realigned output stream.
  always_comb begin
    word_ready = (state_q == IDLE) || final_cyc;
    bit_out    = issue ? {{(SEG_W-1){1'b0}}, cur_bit} : ZERO_CODE;
    sample_idx = issue ? samp_cnt_q : '0;
    zero_out   = ZERO_CODE;
    out_data   = seg_in;
    out_valid  = dly_issue;
    out_last   = dly_final && dly_issue;
    busy       = issue || dly_any;
  end

endmodule

// File: tb/tb_mod_segment_sequencer.sv
// Self-checking bench: directed vector tables, hand-written corner sequences and
// randomized traffic against a queue-based reference model.
module tb_mod_segment_sequencer;

  localparam int unsigned DW  = 8;
  localparam int unsigned SPB = 4;
  localparam int unsigned LAT = 1;

  logic        clk;
  logic        reset;
  logic [7:0]  word_data;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] bit_out;
  logic [31:0] zero_out;
  logic [1:0]  sample_idx;
  logic [31:0] seg_in;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        busy;

  logic        reset6;
  logic [0:0]  word_data6;
  logic        word_valid6;
  logic        word_ready6;
  logic [31:0] bit_out6;
  logic [31:0] zero_out6;
  logic [0:0]  sample_idx6;
  logic [31:0] out_data6;
  logic        out_valid6;
  logic        out_last6;
  logic        busy6;

  mod_segment_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .bit_out    (bit_out),
    .zero_out   (zero_out),
    .sample_idx (sample_idx),
    .seg_in     (seg_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .busy       (busy)
  );

  mod_segment_sequencer #(
    .DATA_W   (1),
    .SPB      (1),
    .IDX_W    (1),
    .PIPE_LAT (3)
  ) dut6 (
    .clk        (clk),
    .reset      (reset6),
    .word_data  (word_data6),
    .word_valid (word_valid6),
    .word_ready (word_ready6),
    .bit_out    (bit_out6),
    .zero_out   (zero_out6),
    .sample_idx (sample_idx6),
    .seg_in     (32'd0),
    .out_data   (out_data6),
    .out_valid  (out_valid6),
    .out_last   (out_last6),
    .busy       (busy6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference waveform value for a sample index (msb always clear).
  function automatic logic [31:0] ref_val(input logic [1:0] i);
    return {14'h0, i, 16'h0055} + 32'h0001_0000;
  endfunction

  function automatic logic [31:0] ref_seg(input logic b, input logic [1:0] i);
    return b ? (32'd0 - ref_val(i)) : ref_val(i);
  endfunction

  // Datapath stand-in: one registered stage, seg = bit ? -ref[idx] : ref[idx].
  always_ff @(posedge clk) seg_in <= ref_seg(bit_out[0], sample_idx);

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {logic b; logic [1:0] idx; logic last;} samp_t;
  typedef struct packed {logic v; logic b; logic [1:0] idx; logic last;} pipe_t;

  samp_t iq[$];   // samples still to be issued, front = this cycle
  pipe_t dq[$];   // issued samples travelling through the datapath
  logic  m_ready;
  logic  model_on;

  task automatic model_reset();
    iq.delete();
    dq.delete();
    for (int i = 0; i < LAT; i++) dq.push_back('0);
  endtask

  task automatic model_check();
    samp_t s;
    pipe_t p;
    logic  issue;
    logic  any;
    issue = (iq.size() > 0);
    s = issue ? iq[0] : '0;
    p = dq[0];
    any = 1'b0;
    foreach (dq[i]) any |= dq[i].v;
    m_ready = (iq.size() <= 1);
    chk("word_ready", 32'(word_ready), 32'(m_ready));
    chk("bit_out", bit_out, 32'(s.b));
    chk("sample_idx", 32'(sample_idx), 32'(s.idx));
    chk("out_valid", 32'(out_valid), 32'(p.v));
    chk("out_last", 32'(out_last), 32'(p.v & p.last));
    chk("busy", 32'(busy), 32'(issue | any));
    chk("zero_out", zero_out, 32'd0);
    if (p.v) chk("out_data", out_data, ref_seg(p.b, p.idx));
  endtask

  task automatic model_step(input logic rst, input logic wv, input logic [7:0] wd);
    samp_t s;
    pipe_t p;
    logic  acc;
    if (rst) begin
      model_reset();
      return;
    end
    acc = wv && (iq.size() <= 1);
    p = '0;
    if (iq.size() > 0) begin
      s = iq.pop_front();
      p = {1'b1, s.b, s.idx, s.last};
    end
    void'(dq.pop_front());
    dq.push_back(p);
    if (acc) begin
      for (int b = 0; b < DW; b++)
        for (int k = 0; k < SPB; k++)
          iq.push_back({wd[b], 2'(k), (b == DW - 1) && (k == SPB - 1)});
    end
  endtask

  // ---------------- observation of the DUT ----------------
  int   obs_vcnt;
  int   obs_first_v;
  int   obs_last_v;
  int   obs_lastpos[$];
  int   obs_hs[$];
  logic obs_bits[$];
  logic [31:0] prev_bit;
  logic [1:0]  prev_idx;

  task automatic obs_clear();
    obs_vcnt = 0;
    obs_first_v = -1;
    obs_last_v = -1;
    obs_lastpos.delete();
    obs_hs.delete();
    obs_bits.delete();
  endtask

  task automatic observe();
    if (out_valid) begin
      obs_vcnt++;
      obs_bits.push_back(out_data[31]);
      if (obs_vcnt == 1) obs_first_v = cyc;
      obs_last_v = cyc;
      if (out_last) obs_lastpos.push_back(obs_vcnt);
    end
    if (word_valid && word_ready && !reset) obs_hs.push_back(cyc);
    if (model_on) begin
      if (bit_out != prev_bit) chk("bit_change_at_wrap", 32'(sample_idx), 32'd0);
      if (sample_idx != 2'd0) chk("idx_step", 32'(sample_idx), 32'(prev_idx + 2'd1));
    end
    prev_bit = bit_out;
    prev_idx = sample_idx;
  endtask

  task automatic sample_cycle(input logic rst, input logic wv, input logic [7:0] wd);
    reset = rst;
    word_valid = wv;
    word_data = wd;
    @(negedge clk);
    if (model_on) model_check();
    observe();
  endtask

  task automatic advance_cycle();
    model_step(reset, word_valid, word_data);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) begin
      sample_cycle(1'b0, 1'b0, 8'h00);
      advance_cycle();
    end
  endtask

  task automatic send_word(input logic [7:0] w);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      sample_cycle(1'b0, 1'b1, w);
      got = m_ready;
      advance_cycle();
    end
    chk("send_accepted", 32'(got), 32'd1);
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic rst; logic wv; logic [7:0] wd;
    logic ready; logic v; logic l; logic busy; logic b; logic [1:0] idx;
  } vec_t;

  typedef struct {
    logic wv; logic ready; logic v; logic l; logic busy;
  } vec6_t;

  vec_t  tab[8];
  vec6_t tab6[6];

  logic [7:0] pat;
  logic       wv_r;
  logic [7:0] wd_r;
  logic       rst_r;
  logic       pend;
  int         sent;
  int         v6;
  int         l6;

  initial begin
    tab[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tab[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tab[2] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tab[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
    tab[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1};
    tab[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2};
    tab[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3};
    tab[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};

    tab6[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tab6[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tab6[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tab6[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tab6[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tab6[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    reset6 = 1'b1;
    word_valid6 = 1'b0;
    word_data6 = 1'b1;
    model_on = 1'b0;
    prev_bit = '0;
    prev_idx = '0;
    model_reset();
    obs_clear();

    // Power-up reset; outputs are undefined until the first edge.
    sample_cycle(1'b1, 1'b0, 8'h00);
    advance_cycle();
    sample_cycle(1'b1, 1'b0, 8'h00);
    advance_cycle();
    model_on = 1'b1;

    // Test 1: reset state then word A5 via the vector table.
    obs_clear();
    for (int i = 0; i < 8; i++) begin
      sample_cycle(tab[i].rst, tab[i].wv, tab[i].wd);
      chk($sformatf("tab%0d_ready", i), 32'(word_ready), 32'(tab[i].ready));
      chk($sformatf("tab%0d_valid", i), 32'(out_valid), 32'(tab[i].v));
      chk($sformatf("tab%0d_last", i), 32'(out_last), 32'(tab[i].l));
      chk($sformatf("tab%0d_busy", i), 32'(busy), 32'(tab[i].busy));
      chk($sformatf("tab%0d_bit", i), bit_out, 32'(tab[i].b));
      chk($sformatf("tab%0d_idx", i), 32'(sample_idx), 32'(tab[i].idx));
      advance_cycle();
    end
    run_idle(40);
    chk("t1_count", 32'(obs_vcnt), 32'd32);
    chk("t1_nlast", 32'(obs_lastpos.size()), 32'd1);
    if (obs_lastpos.size() > 0) chk("t1_lastpos", 32'(obs_lastpos[0]), 32'd32);
    chk("t1_nhs", 32'(obs_hs.size()), 32'd1);
    if (obs_hs.size() > 0) chk("t1_latency", 32'(obs_first_v - obs_hs[0]), 32'd2);
    pat = 8'hA5;
    if (obs_bits.size() >= 32)
      for (int k = 0; k < 8; k++) chk($sformatf("t1_bit%0d", k), 32'(obs_bits[4*k]), 32'(pat[k]));

    // Test 3: index sweep and bit hold within a word.
    pat = 8'h96;
    send_word(pat);
    for (int k = 0; k < 8; k++) begin
      sample_cycle(1'b0, 1'b0, 8'h00);
      chk("t3_idx", 32'(sample_idx), 32'(k % 4));
      chk("t3_bit", bit_out, 32'(pat[k / 4]));
      advance_cycle();
    end
    run_idle(30);

    // Test 2: back-to-back 00 then FF with word_valid held high.
    obs_clear();
    sent = 0;
    for (int i = 0; i < 90; i++) begin
      wv_r = (sent < 2);
      sample_cycle(1'b0, wv_r, (sent == 0) ? 8'h00 : 8'hFF);
      if (wv_r && m_ready) sent++;
      advance_cycle();
    end
    chk("t2_sent", 32'(sent), 32'd2);
    chk("t2_count", 32'(obs_vcnt), 32'd64);
    chk("t2_contig", 32'(obs_last_v - obs_first_v + 1), 32'd64);
    chk("t2_nhs", 32'(obs_hs.size()), 32'd2);
    if (obs_hs.size() == 2) chk("t2_hs_gap", 32'(obs_hs[1] - obs_hs[0]), 32'd32);
    chk("t2_nlast", 32'(obs_lastpos.size()), 32'd2);
    if (obs_lastpos.size() == 2) begin
      chk("t2_last0", 32'(obs_lastpos[0]), 32'd32);
      chk("t2_last1", 32'(obs_lastpos[1]), 32'd64);
    end

    // Test 4: reset at sample 10 of 3C, then a clean burst of 01.
    obs_clear();
    send_word(8'h3C);
    for (int i = 0; i < 40 && obs_vcnt < 10; i++) begin
      sample_cycle(1'b0, 1'b0, 8'h00);
      advance_cycle();
    end
    chk("t4_reached10", 32'(obs_vcnt >= 10), 32'd1);
    sample_cycle(1'b1, 1'b0, 8'h00);
    advance_cycle();
    sample_cycle(1'b0, 1'b0, 8'h00);
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_last", 32'(out_last), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_ready", 32'(word_ready), 32'd1);
    advance_cycle();
    obs_clear();
    send_word(8'h01);
    run_idle(40);
    chk("t4_count", 32'(obs_vcnt), 32'd32);
    chk("t4_nlast", 32'(obs_lastpos.size()), 32'd1);
    if (obs_lastpos.size() > 0) chk("t4_lastpos", 32'(obs_lastpos[0]), 32'd32);

    // Test 5: five idle cycles between words.
    obs_clear();
    send_word(8'h5A);
    run_idle(33);
    for (int i = 0; i < 5; i++) begin
      sample_cycle(1'b0, 1'b0, 8'h00);
      chk("t5_ready", 32'(word_ready), 32'd1);
      chk("t5_valid", 32'(out_valid), 32'd0);
      chk("t5_last", 32'(out_last), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      advance_cycle();
    end
    send_word(8'hC3);
    run_idle(34);
    chk("t5_count", 32'(obs_vcnt), 32'd64);
    chk("t5_nlast", 32'(obs_lastpos.size()), 32'd2);
    if (obs_lastpos.size() == 2) begin
      chk("t5_last0", 32'(obs_lastpos[0]), 32'd32);
      chk("t5_last1", 32'(obs_lastpos[1]), 32'd64);
    end

    // Randomized traffic; the source holds a word until it is taken.
    pend = 1'b0;
    wv_r = 1'b0;
    wd_r = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      if (!pend) begin
        wv_r = ($urandom_range(0, 3) != 0);
        wd_r = 8'($urandom);
      end
      rst_r = ($urandom_range(0, 199) == 0);
      sample_cycle(rst_r, wv_r, wd_r);
      pend = wv_r && !m_ready && !rst_r;
      advance_cycle();
    end
    run_idle(40);
    model_on = 1'b0;

    // Test 6: DATA_W=1, SPB=1, PIPE_LAT=3 instance.
    reset = 1'b0;
    word_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      reset6 = 1'b1;
      @(posedge clk);
      #1;
    end
    reset6 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      word_valid6 = tab6[i].wv;
      @(negedge clk);
      chk($sformatf("t6_%0d_ready", i), 32'(word_ready6), 32'(tab6[i].ready));
      chk($sformatf("t6_%0d_valid", i), 32'(out_valid6), 32'(tab6[i].v));
      chk($sformatf("t6_%0d_last", i), 32'(out_last6), 32'(tab6[i].l));
      chk($sformatf("t6_%0d_busy", i), 32'(busy6), 32'(tab6[i].busy));
      @(posedge clk);
      #1;
    end
    v6 = 0;
    l6 = 0;
    for (int i = 0; i < 10; i++) begin
      word_valid6 = (i < 3);
      @(negedge clk);
      if (out_valid6) v6++;
      if (out_last6) l6++;
      @(posedge clk);
      #1;
    end
    chk("t6_burst_valid", 32'(v6), 32'd3);
    chk("t6_burst_last", 32'(l6), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
